// File: rtl/deferred_writeback_seq.sv
`default_nettype none
// ============================================================================
// Module   : deferred_writeback_seq
// Purpose  : Queues destination registers of completing instructions and
//            replays their SB->register load strobe at a chosen T-state.
// Revision : 1.0 - initial release
// ============================================================================
module deferred_writeback_seq #(
  parameter int                 NUM_DEST = 3,
  parameter int                 T_WIDTH  = 7,
  parameter logic [T_WIDTH-1:0] WB_T     = 7'b0000100,
  parameter int                 DEPTH    = 2
) (
  input  logic                phi2,
  input  logic                rst_n,
  input  logic [T_WIDTH-1:0]  T,
  input  logic                op_done,
  input  logic [NUM_DEST-1:0] dest_sel,
  input  logic                hold,
  input  logic                flush,
  input  logic [NUM_DEST-1:0] rd_sel,
  output logic [NUM_DEST-1:0] wb_load,
  output logic [NUM_DEST-1:0] pending,
  output logic                hazard,
  output logic                overflow,
  output logic                sel_err
);

  localparam int                  PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                  CNT_W      = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0]    C_LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]    C_FULL     = CNT_W'(DEPTH);
  localparam logic [NUM_DEST-1:0] C_ONE      = NUM_DEST'(1);

  logic [NUM_DEST-1:0] r_slot [DEPTH];
  logic [DEPTH-1:0]    r_vld;
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;
  logic                r_overflow;
  logic                r_sel_err;

  logic                w_fire;
  logic                w_multi;
  logic                w_onehot;
  logic                w_full;
  logic                w_push_req;
  logic                w_push;
  logic                w_drop;
  logic [DEPTH-1:0]    w_vld_nxt;
  logic [NUM_DEST-1:0] w_pending;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
    return (p == C_LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_fire     = (r_count != '0) && (T == WB_T) && !hold && !flush;
  assign w_multi    = (dest_sel & (dest_sel - C_ONE)) != '0;
  assign w_onehot   = (dest_sel != '0) && !w_multi;
  assign w_full     = (r_count == C_FULL);
  assign w_push_req = op_done && w_onehot && !flush;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign w_push     = w_push_req && (!w_full || w_fire);
  assign w_drop     = w_push_req && w_full && !w_fire;

  always_comb begin
    w_vld_nxt = r_vld;
    if (w_fire) w_vld_nxt[r_head] = 1'b0;
    if (w_push) w_vld_nxt[r_tail] = 1'b1;
  end

  // Valid bits gate the OR so stale slot contents never show up.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) w_pending = w_pending | r_slot[i];
    end
  end

  always_ff @(posedge phi2 or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_vld      <= '0;
      r_overflow <= 1'b0;
      r_sel_err  <= 1'b0;
    end else begin
      if (op_done && w_multi) r_sel_err  <= 1'b1;
      if (w_drop)             r_overflow <= 1'b1;
      if (flush) begin
        r_count <= '0;
        r_head  <= r_tail;
        r_vld   <= '0;
      end else begin
        r_vld <= w_vld_nxt;
        if (w_fire) r_head <= f_next_ptr(r_head);
        if (w_push) r_tail <= f_next_ptr(r_tail);
        if (w_push && !w_fire)      r_count <= r_count + CNT_W'(1);
        else if (w_fire && !w_push) r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Slot payload needs no reset; validity is tracked by r_vld.
  always_ff @(posedge phi2) begin
    if (w_push) r_slot[r_tail] <= dest_sel;
  end

  assign wb_load  = w_fire ? r_slot[r_head] : '0;
  assign pending  = w_pending;
  assign hazard   = |(rd_sel & w_pending);
  assign overflow = r_overflow;
  assign sel_err  = r_sel_err;

endmodule
`default_nettype wire
